uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_pkg.sv | 16 +
 rtl/uart_rx_fifo_sync_fifo.sv | 63 ++++++
 rtl/uart_rx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: bit-level FSM states and
// default frame timing for the 100 MHz system clock.
package uart_rx_fifo_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_DEPTH        = 16;
    localparam int FRAME_DATA_BITS      = 8;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always presented on pop_data.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // A pop while empty is ignored; a pop frees the slot a full-FIFO push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: synchronises the serial pin, deserialises frames and
// buffers received bytes in a show-ahead FIFO with sticky error flags.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH        = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   rxd,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   frame_err,
    output logic                   overrun,
    input  logic                   clr_err
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic                       rxd_meta;
    logic                       rxd_s;
    rx_state_e                  state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [2:0]                 bit_q, bit_d;
    logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
    logic                       push;
    logic                       frame_bad;
    logic                       half_done;
    logic                       bit_done;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       overrun_set;

    // Both flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign half_done = (cnt_q == CNT_W'(HALF - 1));
    assign bit_done  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_bad = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rxd_s) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (half_done) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[FRAME_DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                // Returning at mid-stop lets a back-to-back start bit be caught.
                if (bit_done) begin
                    cnt_d     = '0;
                    state_d   = RX_IDLE;
                    push      = rxd_s;
                    frame_bad = !rxd_s;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (FRAME_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (shift_q),
        .full      (fifo_full),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rx_valid    = !fifo_empty;
    assign overrun_set = push && fifo_full && !rx_ready;

    // A set event takes priority over a coincident clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_bad) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed corner cases, a table of
// frames with hand-computed results, and random frames against a queue model.
module tb_uart_rx_fifo;

    localparam int C        = 16;
    localparam int D        = 4;
    localparam int H        = C / 2;
    localparam int SAMPLE_J = H + 9 * C + 2;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic       m_ferr;
    logic       m_ovr;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pop_at_stop;
        logic [2:0] exp_count;
        logic [7:0] exp_head;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[7];

    uart_rx_fifo #(
        .CLKS_PER_BIT (C),
        .DEPTH        (D)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " valid"}, rx_valid, exp_q.size() != 0);
        check({tag, " count"}, fifo_count, exp_q.size());
        check({tag, " frame_err"}, frame_err, m_ferr);
        check({tag, " overrun"}, overrun, m_ovr);
        if (exp_q.size() != 0) begin
            check({tag, " data"}, rx_data, exp_q[0]);
        end
    endtask

    // Reference behaviour of one completed frame, from the byte-level rules.
    task automatic model_frame(input logic [7:0] d, input logic stop, input logic pop, input logic clr);
        logic popping;
        logic room;
        if (clr) begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        popping = pop && (exp_q.size() != 0);
        room    = (exp_q.size() < D) || popping;
        if (popping) begin
            void'(exp_q.pop_front());
        end
        if (!stop) begin
            m_ferr = 1'b1;
        end else if (room) begin
            exp_q.push_back(d);
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic send_frame(input string tag, input logic [7:0] d, input logic stop,
                              input logic pop_at_stop, input logic clr_at_stop, input int gap);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int j = 0; j < 10 * C; j++) begin
            rxd = bits[j / C];
            if (j == SAMPLE_J) begin
                check_state({tag, " pre-stop"});
                rx_ready = pop_at_stop;
                clr_err  = clr_at_stop;
            end
            if (j == SAMPLE_J + 1) begin
                rx_ready = 1'b0;
                clr_err  = 1'b0;
                model_frame(d, stop, pop_at_stop, clr_at_stop);
                check_state({tag, " post-stop"});
            end
            @(negedge clk);
        end
        rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pop_one(input string tag);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
        check_state(tag);
    endtask

    // Consecutive pops with rx_ready held high, one byte per cycle.
    task automatic drain(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " drain valid"}, rx_valid, 1'b1);
            check({tag, " drain data"}, rx_data, exp_q[0]);
            rx_ready = 1'b1;
            @(negedge clk);
            void'(exp_q.pop_front());
        end
        rx_ready = 1'b0;
        check_state({tag, " drained"});
    endtask

    task automatic clear_errors(input string tag);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        check_state(tag);
    endtask

    initial begin
        resetn   = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        clr_err  = 1'b0;
        m_ferr   = 1'b0;
        m_ovr    = 1'b0;

        vecs[0] = '{8'h11, 1'b1, 1'b0, 3'd1, 8'h11, 1'b0, 1'b0};
        vecs[1] = '{8'h22, 1'b0, 1'b0, 3'd1, 8'h11, 1'b1, 1'b0};
        vecs[2] = '{8'h33, 1'b1, 1'b0, 3'd2, 8'h11, 1'b1, 1'b0};
        vecs[3] = '{8'h44, 1'b1, 1'b1, 3'd2, 8'h33, 1'b1, 1'b0};
        vecs[4] = '{8'h55, 1'b1, 1'b0, 3'd3, 8'h33, 1'b1, 1'b0};
        vecs[5] = '{8'h66, 1'b1, 1'b0, 3'd4, 8'h33, 1'b1, 1'b0};
        vecs[6] = '{8'h77, 1'b1, 1'b0, 3'd4, 8'h33, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check_state("reset");
        check("reset data", rx_data, 8'h00);
        resetn = 1'b1;
        repeat (C) @(negedge clk);

        send_frame("nominal", 8'hA5, 1'b1, 1'b0, 1'b0, C);
        check("nominal data", rx_data, 8'hA5);
        pop_one("nominal pop");

        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * C) @(negedge clk);
        check_state("glitch");
        send_frame("after glitch", 8'h3C, 1'b1, 1'b0, 1'b0, C);
        drain("after glitch");

        send_frame("frame err", 8'h55, 1'b0, 1'b0, 1'b0, C);
        clear_errors("frame err clr");

        for (int i = 1; i <= 5; i++) begin
            send_frame("overrun", 8'(i), 1'b1, 1'b0, 1'b0, 0);
        end
        repeat (C) @(negedge clk);
        check("overrun count", fifo_count, 3'd4);
        check("overrun flag", overrun, 1'b1);
        drain("overrun");
        clear_errors("overrun clr");

        for (int i = 0; i < 5; i++) begin
            send_frame("push+pop", 8'h10 + 8'(i), 1'b1, i == 4, 1'b0, 0);
        end
        repeat (C) @(negedge clk);
        check("push+pop count", fifo_count, 3'd4);
        check("push+pop overrun", overrun, 1'b0);
        check("push+pop head", rx_data, 8'h11);
        drain("push+pop");

        foreach (vecs[k]) begin
            send_frame("table", vecs[k].data, vecs[k].stop, vecs[k].pop_at_stop, 1'b0, C);
            check("table count", fifo_count, vecs[k].exp_count);
            check("table head", rx_data, vecs[k].exp_head);
            check("table frame_err", frame_err, vecs[k].exp_ferr);
            check("table overrun", overrun, vecs[k].exp_ovr);
        end
        drain("table");
        clear_errors("table clr");

        for (int i = 0; i < 30; i++) begin
            int npop;
            send_frame("random", 8'($urandom), $urandom_range(0, 6) != 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                       C + $urandom_range(0, C));
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) begin
                pop_one("random pop");
            end
            if ($urandom_range(0, 5) == 0) begin
                clear_errors("random clr");
            end
        end

        send_frame("pre-reset", 8'h9A, 1'b1, 1'b0, 1'b0, C);
        send_frame("pre-reset err", 8'h00, 1'b0, 1'b0, 1'b0, C);
        rxd = 1'b0;
        for (int j = 1; j < C + 3 * C + H; j++) begin
            @(negedge clk);
            rxd = (8'hF0 >> ((j / C) - 1)) & 1'b1;
            if (j < C) rxd = 1'b0;
        end
        resetn = 1'b0;
        rxd    = 1'b1;
        #1;
        exp_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_state("mid-frame reset");
        check("mid-frame reset data", rx_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (C) @(negedge clk);
        check_state("after reset idle");
        send_frame("after reset", 8'hF0, 1'b1, 1'b0, 1'b0, C);
        check("after reset data", rx_data, 8'hF0);
        drain("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
